// File: rtl/controle_desvio.sv
// Branch/jump control sequencer: decodes one instruction per handshake and drives the next-PC selector.
// Optional BRANCH_STATS_EN adds saturating branch / taken-branch counters.
module controle_desvio #(
    parameter int unsigned FLAG_TIMEOUT = 15
`ifdef BRANCH_STATS_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        alu_valid,
    input  logic        zero,
    input  logic        neg,
    output logic        PCSrc,
    output logic [2:0]  Tipo_Branch,
    output logic [31:0] imed,
    output logic        pc_we,
    output logic        illegal,
    output logic        timeout
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0] n_desvios,
    output logic [CNT_W-1:0] n_tomados
`endif
);

    localparam int unsigned TMO_W = 8;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FLAG_TIMEOUT - 1);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {IDLE, DECODE, WAIT_FLAGS, COMMIT} state_t;

    state_t            state_q, state_d;
    logic [31:0]       instr_q, instr_d;
    logic [TMO_W-1:0]  cnt_q, cnt_d;
    logic              pcsrc_d, pc_we_d, illegal_d, timeout_d, ready_d;
    logic [2:0]        tipo_d;
    logic [31:0]       imed_d;

    // Word offsets: byte offset sign-extended, then arithmetic shift by 2
    logic signed [12:0] b_off;
    logic signed [20:0] j_off;
    logic [31:0]        b_imm, j_imm;

    assign b_off = {instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
    assign j_off = {instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
    assign b_imm = 32'(b_off >>> 2);
    assign j_imm = 32'(j_off >>> 2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            instr_q     <= '0;
            cnt_q       <= '0;
            PCSrc       <= 1'b0;
            Tipo_Branch <= 3'd0;
            imed        <= '0;
            pc_we       <= 1'b0;
            illegal     <= 1'b0;
            timeout     <= 1'b0;
            instr_ready <= 1'b1;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            cnt_q       <= cnt_d;
            PCSrc       <= pcsrc_d;
            Tipo_Branch <= tipo_d;
            imed        <= imed_d;
            pc_we       <= pc_we_d;
            illegal     <= illegal_d;
            timeout     <= timeout_d;
            instr_ready <= ready_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        cnt_d     = cnt_q;
        pcsrc_d   = PCSrc;
        tipo_d    = Tipo_Branch;
        imed_d    = imed;
        illegal_d = 1'b0;
        timeout_d = 1'b0;
        pc_we_d   = 1'b0;
        ready_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                cnt_d   = '0;
                state_d = COMMIT;
                pcsrc_d = 1'b0;
                tipo_d  = 3'd0;
                imed_d  = '0;
                unique case (instr_q[6:0])
                    OP_BRANCH: begin
                        imed_d  = b_imm;
                        state_d = WAIT_FLAGS;
                        unique case (instr_q[14:12])
                            3'b000:  tipo_d = 3'd1;
                            3'b001:  tipo_d = 3'd2;
                            3'b100:  tipo_d = 3'd3;
                            3'b101:  tipo_d = 3'd4;
                            default: begin
                                illegal_d = 1'b1;
                                imed_d    = '0;
                                state_d   = COMMIT;
                            end
                        endcase
                    end
                    OP_JAL: begin
                        tipo_d  = 3'd6;
                        imed_d  = j_imm;
                        pcsrc_d = 1'b1;
                    end
                    OP_JALR: begin
                        tipo_d  = 3'd7;
                        pcsrc_d = 1'b1;
                    end
                    default: ;
                endcase
            end
            WAIT_FLAGS: begin
                // alu_valid takes priority over the terminal count
                if (alu_valid) begin
                    pcsrc_d = 1'b1;
                    state_d = COMMIT;
                end else if (cnt_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    pcsrc_d   = 1'b0;
                    state_d   = COMMIT;
                end else begin
                    cnt_d = TMO_W'(cnt_q + 1'b1);
                end
            end
            COMMIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        pc_we_d = (state_d == COMMIT) && (state_q != COMMIT);
        ready_d = (state_d == IDLE);
    end

`ifdef BRANCH_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic is_cond, taken;

    always_comb begin
        is_cond = (Tipo_Branch >= 3'd1) && (Tipo_Branch <= 3'd4);
        taken   = 1'b0;
        unique case (Tipo_Branch)
            3'd1:    taken = zero;
            3'd2:    taken = !zero;
            3'd3:    taken = neg;
            3'd4:    taken = zero || !neg;
            default: taken = 1'b0;
        endcase
        // A timed-out branch is forced not-taken and reaches COMMIT with PCSrc low
        taken = taken && PCSrc && is_cond;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_desvios <= '0;
            n_tomados <= '0;
        end else if (state_q == COMMIT && is_cond) begin
            if (n_desvios != CNT_MAX) n_desvios <= CNT_W'(n_desvios + 1'b1);
            if (taken && n_tomados != CNT_MAX) n_tomados <= CNT_W'(n_tomados + 1'b1);
        end
    end
`else
    logic flags_unused;
    assign flags_unused = ^{zero, neg};
`endif

endmodule
